// File: rtl/npc_mem_pkg.sv
// Shared encodings for the npc memory-port arbiter: access sizes, owner and FSM state.
package npc_mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: bit 0 = IFU, bit 1 = LSU. Ties go to the side
// that was not granted last. Purely combinational; history lives in the caller.
module rr_arbiter2
    import npc_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant; on a tie favour the requester that did not win last time.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = (last_grant == OWN_LSU) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between IFU and LSU. One transaction is in
// flight at a time (IDLE -> REQ -> WAIT -> RESP); a watchdog turns a hung
// downstream response into an error response to the owner.
module mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_W-1:0]     ifu_resp_rdata,
    output logic                  ifu_resp_err,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    input  logic [1:0]            lsu_req_size,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_W-1:0]     lsu_resp_rdata,
    output logic                  lsu_resp_err,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    output logic [1:0]            mem_req_size,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [DATA_W-1:0]     mem_resp_rdata
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [1:0]          size_q, size_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [1:0]          req_vec;
    logic [1:0]          grant;
    logic [CNT_W-1:0]    cnt_inc;
    logic                timeout_hit;
    logic                owner_resp_ready;
    logic                in_resp;

    // Requests are only visible to the arbiter while idle.
    assign req_vec = (state_q == IDLE) ? {lsu_req_valid, ifu_req_valid} : 2'b00;

    rr_arbiter2 u_rr (
        .req        (req_vec),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign cnt_inc          = cnt_q + CNT_W'(1);
    assign timeout_hit      = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));
    assign owner_resp_ready = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
    assign in_resp          = (state_q == RESP);

    // Next-state, capture and watchdog logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        size_d       = size_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (grant[1]) begin
                    owner_d = OWN_LSU;
                    addr_d  = lsu_req_addr;
                    wen_d   = lsu_req_wen;
                    wdata_d = lsu_req_wdata;
                    wmask_d = lsu_req_wmask;
                    size_d  = lsu_req_size;
                    state_d = REQ;
                end else if (grant[0]) begin
                    // Fetches are always plain word reads.
                    owner_d = OWN_IFU;
                    addr_d  = ifu_req_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    size_d  = SZ_W;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response arriving on the timeout cycle still wins.
                if (mem_resp_valid) begin
                    rdata_d = wen_q ? '0 : mem_resp_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                if (owner_resp_ready) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers; reset drops any outstanding transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            size_q       <= 2'b00;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            size_q       <= size_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ifu_req_ready  = grant[0];
    assign lsu_req_ready  = grant[1];

    assign mem_req_valid  = (state_q == REQ);
    assign mem_req_addr   = addr_q;
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;
    assign mem_req_size   = size_q;
    // IDLE also absorbs stray responses so they never stall the memory side.
    assign mem_resp_ready = (state_q == IDLE) || (state_q == WAIT);

    assign ifu_resp_valid = in_resp && (owner_q == OWN_IFU);
    assign ifu_resp_rdata = (owner_q == OWN_IFU) ? rdata_q : '0;
    assign ifu_resp_err   = in_resp && (owner_q == OWN_IFU) && err_q;

    assign lsu_resp_valid = in_resp && (owner_q == OWN_LSU);
    assign lsu_resp_rdata = (owner_q == OWN_LSU) ? rdata_q : '0;
    assign lsu_resp_err   = in_resp && (owner_q == OWN_LSU) && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: main instance with default watchdog plus a
// second instance with TIMEOUT = 4 for the watchdog scenario.
module tb_mem_arbiter;
    import npc_mem_pkg::*;

    localparam logic [31:0] KEY = 32'h1234_5678;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [1:0]  size;
    } mreq_t;

    typedef struct packed {
        logic        lsu;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [31:0] ifu_req_addr, ifu_resp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
    logic [3:0]  lsu_req_wmask;
    logic [1:0]  lsu_req_size;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
    logic [3:0]  mem_req_wmask;
    logic [1:0]  mem_req_size;

    logic        t_ifu_req_valid, t_ifu_req_ready, t_ifu_resp_valid, t_ifu_resp_ready, t_ifu_resp_err;
    logic [31:0] t_ifu_resp_rdata, t_lsu_resp_rdata, t_mem_req_addr, t_mem_req_wdata;
    logic        t_lsu_req_valid, t_lsu_req_ready, t_lsu_resp_valid, t_lsu_resp_ready, t_lsu_resp_err;
    logic        t_mem_req_valid, t_mem_req_ready, t_mem_req_wen, t_mem_resp_valid, t_mem_resp_ready;
    logic [3:0]  t_mem_req_wmask;
    logic [1:0]  t_mem_req_size;

    logic        use_fixed;
    logic [31:0] fixed_data;
    // Memory returns either a fixed word or a word derived from the held request address.
    assign mem_resp_rdata = use_fixed ? fixed_data : (mem_req_addr ^ KEY);

    mem_arbiter u_dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_req_size(lsu_req_size), .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_req_size(mem_req_size), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_rdata(mem_resp_rdata)
    );

    mem_arbiter #(.TIMEOUT(4)) u_to (
        .clk(clk), .reset(reset),
        .ifu_req_valid(t_ifu_req_valid), .ifu_req_ready(t_ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(t_ifu_resp_valid), .ifu_resp_ready(t_ifu_resp_ready),
        .ifu_resp_rdata(t_ifu_resp_rdata), .ifu_resp_err(t_ifu_resp_err),
        .lsu_req_valid(t_lsu_req_valid), .lsu_req_ready(t_lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_req_size(lsu_req_size), .lsu_resp_valid(t_lsu_resp_valid), .lsu_resp_ready(t_lsu_resp_ready),
        .lsu_resp_rdata(t_lsu_resp_rdata), .lsu_resp_err(t_lsu_resp_err),
        .mem_req_valid(t_mem_req_valid), .mem_req_ready(t_mem_req_ready), .mem_req_addr(t_mem_req_addr),
        .mem_req_wen(t_mem_req_wen), .mem_req_wdata(t_mem_req_wdata), .mem_req_wmask(t_mem_req_wmask),
        .mem_req_size(t_mem_req_size), .mem_resp_valid(t_mem_resp_valid), .mem_resp_ready(t_mem_resp_ready),
        .mem_resp_rdata(mem_resp_rdata)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lsu_valid_cnt = 0;

    mreq_t exp_mreq[$], obs_mreq[$];
    resp_t exp_resp[$], obs_resp[$];
    logic  obs_grant[$];
    int    obs_acc_cyc[$], obs_resp_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: records every handshake of the main instance.
    always @(negedge clk) begin
        if (!reset) begin
            if (lsu_resp_valid) lsu_valid_cnt <= lsu_valid_cnt + 1;
            if (ifu_req_valid && ifu_req_ready) begin
                obs_grant.push_back(1'b0); obs_acc_cyc.push_back(cyc);
            end
            if (lsu_req_valid && lsu_req_ready) begin
                obs_grant.push_back(1'b1); obs_acc_cyc.push_back(cyc);
            end
            if (mem_req_valid && mem_req_ready)
                obs_mreq.push_back('{mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_req_size});
            if (ifu_resp_valid && ifu_resp_ready) begin
                obs_resp.push_back('{1'b0, ifu_resp_rdata, ifu_resp_err}); obs_resp_cyc.push_back(cyc);
            end
            if (lsu_resp_valid && lsu_resp_ready) begin
                obs_resp.push_back('{1'b1, lsu_resp_rdata, lsu_resp_err}); obs_resp_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_queues();
        exp_mreq.delete(); obs_mreq.delete(); exp_resp.delete(); obs_resp.delete();
        obs_grant.delete(); obs_acc_cyc.delete(); obs_resp_cyc.delete();
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 0; lsu_req_valid = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
        mem_req_ready = 0; mem_resp_valid = 0;
        t_ifu_req_valid = 0; t_lsu_req_valid = 0; t_ifu_resp_ready = 0; t_lsu_resp_ready = 1;
        t_mem_req_ready = 0; t_mem_resp_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1; tick(); reset = 0; clear_queues();
    endtask

    // Drives one request until the main DUT accepts it (bounded).
    task automatic issue(input logic lsu, input mreq_t r, output logic ok);
        ok = 0;
        if (lsu) begin
            lsu_req_valid = 1; lsu_req_addr = r.addr; lsu_req_wen = r.wen;
            lsu_req_wdata = r.wdata; lsu_req_wmask = r.wmask; lsu_req_size = r.size;
        end else begin
            ifu_req_valid = 1; ifu_req_addr = r.addr;
        end
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if ((lsu && lsu_req_ready) || (!lsu && ifu_req_ready)) ok = 1;
            tick();
        end
        if (lsu) lsu_req_valid = 0; else ifu_req_valid = 0;
    endtask

    task automatic wait_resps(input int n, output logic ok);
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            if (obs_resp.size() >= n) ok = 1; else tick();
        end
    endtask

    task automatic t_accept(output logic ok);
        ok = 0;
        t_ifu_req_valid = 1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (t_ifu_req_ready) ok = 1;
            tick();
        end
        t_ifu_req_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs(); use_fixed = 1; fixed_data = 0;
        ifu_req_addr = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0;
        lsu_req_wmask = 0; lsu_req_size = 0;
        reset = 1; tick(); tick(); reset = 0; #1;
        checks++;
        if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready} !== 5'b0) begin
            failures++; $display("FAIL reset_valids got %b exp 00000",
                {mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready});
        end
        checks++;
        if (mem_resp_ready !== 1'b1) begin
            failures++; $display("FAIL reset_mem_resp_ready got %b exp 1", mem_resp_ready);
        end
        checks++;
        if ({ifu_resp_err, lsu_resp_err} !== 2'b00) begin
            failures++; $display("FAIL reset_err got %b exp 00", {ifu_resp_err, lsu_resp_err});
        end
        checks++;
        if ({mem_req_addr, mem_req_wdata, mem_req_wmask, ifu_resp_rdata, lsu_resp_rdata} !== '0) begin
            failures++; $display("FAIL reset_data got addr=%h wdata=%h ird=%h lrd=%h exp 0",
                mem_req_addr, mem_req_wdata, ifu_resp_rdata, lsu_resp_rdata);
        end
        clear_queues();
    endtask

    task automatic test_ifu_read();
        logic ok;
        mreq_t r, om; resp_t er, orr;
        r = '{32'h8000_0000, 1'b0, 32'h0, 4'h0, SZ_W};
        ifu_resp_ready = 1; lsu_resp_ready = 1;
        mem_req_ready = 1; mem_resp_valid = 1; use_fixed = 1; fixed_data = 32'h0010_0073;
        lsu_valid_cnt = 0;
        exp_mreq.push_back(r); exp_resp.push_back('{1'b0, 32'h0010_0073, 1'b0});
        issue(1'b0, r, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ifu_accept got none exp accept"); end
        wait_resps(1, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL ifu_resp_timeout got %0d resps exp 1", obs_resp.size());
        end else begin
            om = obs_mreq.pop_front(); r = exp_mreq.pop_front();
            checks++;
            if (om !== r) begin failures++; $display("FAIL ifu_mreq got %h exp %h", om, r); end
            orr = obs_resp.pop_front(); er = exp_resp.pop_front();
            checks++;
            if (orr !== er) begin failures++; $display("FAIL ifu_resp got %h exp %h", orr, er); end
            checks++;
            if (obs_resp_cyc[0] - obs_acc_cyc[0] !== 3) begin
                failures++; $display("FAIL ifu_latency got %0d exp 3", obs_resp_cyc[0] - obs_acc_cyc[0]);
            end
        end
        tick();
        checks++;
        if (lsu_valid_cnt !== 0) begin
            failures++; $display("FAIL ifu_lsu_quiet got %0d lsu valid cycles exp 0", lsu_valid_cnt);
        end
        idle_inputs(); tick(); clear_queues();
    endtask

    task automatic test_tie();
        logic ok;
        logic exp_g [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        mreq_t ri, rl, om, em; resp_t orr, er;
        do_reset();
        ri = '{32'h8000_0004, 1'b0, 32'h0, 4'h0, SZ_W};
        rl = '{32'h8000_1000, 1'b0, 32'h0, 4'h0, SZ_W};
        for (int k = 0; k < 4; k++) begin
            exp_mreq.push_back(exp_g[k] ? rl : ri);
            exp_resp.push_back('{exp_g[k], (exp_g[k] ? rl.addr : ri.addr) ^ KEY, 1'b0});
        end
        ifu_resp_ready = 1; lsu_resp_ready = 1; mem_req_ready = 1; mem_resp_valid = 1; use_fixed = 0;
        ifu_req_valid = 1; ifu_req_addr = ri.addr;
        lsu_req_valid = 1; lsu_req_addr = rl.addr; lsu_req_wen = 0; lsu_req_wdata = 0;
        lsu_req_wmask = 0; lsu_req_size = SZ_W;
        for (int i = 0; i < 40 && obs_grant.size() < 4; i++) tick();
        ifu_req_valid = 0; lsu_req_valid = 0;
        wait_resps(4, ok);
        checks++;
        if (!ok || obs_grant.size() != 4) begin
            failures++; $display("FAIL tie_count got grants=%0d resps=%0d exp 4", obs_grant.size(), obs_resp.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs_grant[k] !== exp_g[k]) begin
                    failures++; $display("FAIL tie_grant%0d got %b exp %b", k, obs_grant[k], exp_g[k]);
                end
                om = obs_mreq.pop_front(); em = exp_mreq.pop_front();
                checks++;
                if (om !== em) begin failures++; $display("FAIL tie_mreq%0d got %h exp %h", k, om, em); end
                orr = obs_resp.pop_front(); er = exp_resp.pop_front();
                checks++;
                if (orr !== er) begin failures++; $display("FAIL tie_resp%0d got %h exp %h", k, orr, er); end
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_acc_cyc[k+1] - obs_acc_cyc[k] !== 4) begin
                    failures++; $display("FAIL tie_spacing%0d got %0d exp 4", k, obs_acc_cyc[k+1] - obs_acc_cyc[k]);
                end
            end
        end
        idle_inputs(); tick(); clear_queues();
    endtask

    task automatic test_lsu_store();
        logic ok;
        mreq_t r, om; resp_t er, orr;
        r = '{32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 4'b0001, SZ_B};
        lsu_resp_ready = 1; mem_req_ready = 1; mem_resp_valid = 1; use_fixed = 0;
        exp_mreq.push_back(r); exp_resp.push_back('{1'b1, 32'h0, 1'b0});
        issue(1'b1, r, ok);
        wait_resps(1, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL store_resp_timeout got %0d resps exp 1", obs_resp.size());
        end else begin
            om = obs_mreq.pop_front(); r = exp_mreq.pop_front();
            checks++;
            if (om !== r) begin failures++; $display("FAIL store_mreq got %h exp %h", om, r); end
            orr = obs_resp.pop_front(); er = exp_resp.pop_front();
            checks++;
            if (orr !== er) begin failures++; $display("FAIL store_resp got %h exp %h", orr, er); end
        end
        idle_inputs(); tick(); clear_queues();
    endtask

    task automatic test_backpressure();
        logic ok;
        mreq_t r, cur, om; resp_t er, orr;
        r = '{32'h8000_3000, 1'b0, 32'h0, 4'h0, SZ_H};
        idle_inputs(); use_fixed = 1; fixed_data = 32'hCAFE_F00D;
        exp_mreq.push_back(r); exp_resp.push_back('{1'b1, 32'hCAFE_F00D, 1'b0});
        issue(1'b1, r, ok);
        lsu_req_addr = 32'h1234_5678; lsu_req_wdata = 32'hFFFF_FFFF; lsu_req_wen = 1;
        for (int i = 0; i < 5; i++) begin
            cur = '{mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_req_size};
            checks++;
            if (mem_req_valid !== 1'b1 || cur !== r) begin
                failures++; $display("FAIL bp_req_hold%0d got v=%b %h exp v=1 %h", i, mem_req_valid, cur, r);
            end
            tick();
        end
        mem_req_ready = 1; tick(); mem_req_ready = 0;
        ifu_req_valid = 1;
        for (int i = 0; i < 7; i++) begin
            #1;
            checks++;
            if ({lsu_resp_valid, mem_resp_ready, ifu_req_ready, mem_req_valid} !== 4'b0100) begin
                failures++; $display("FAIL bp_wait%0d got %b exp 0100",
                    i, {lsu_resp_valid, mem_resp_ready, ifu_req_ready, mem_req_valid});
            end
            tick();
        end
        ifu_req_valid = 0; mem_resp_valid = 1; tick(); mem_resp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({lsu_resp_valid, ifu_resp_valid, lsu_resp_err} !== 3'b100 || lsu_resp_rdata !== 32'hCAFE_F00D) begin
                failures++; $display("FAIL bp_resp_hold%0d got v/iv/err=%b rd=%h exp 100 cafef00d",
                    i, {lsu_resp_valid, ifu_resp_valid, lsu_resp_err}, lsu_resp_rdata);
            end
            tick();
        end
        lsu_resp_ready = 1; tick(); lsu_resp_ready = 0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (obs_resp.size() !== 1 || lsu_resp_valid !== 1'b0) begin
            failures++; $display("FAIL bp_single_resp got %0d resps valid=%b exp 1 resp valid=0",
                obs_resp.size(), lsu_resp_valid);
        end
        if (obs_resp.size() > 0 && obs_mreq.size() > 0) begin
            om = obs_mreq.pop_front(); r = exp_mreq.pop_front();
            checks++;
            if (om !== r) begin failures++; $display("FAIL bp_mreq got %h exp %h", om, r); end
            orr = obs_resp.pop_front(); er = exp_resp.pop_front();
            checks++;
            if (orr !== er) begin failures++; $display("FAIL bp_resp got %h exp %h", orr, er); end
        end
        idle_inputs(); tick(); clear_queues();
    endtask

    task automatic test_timeout();
        logic ok;
        int n;
        idle_inputs(); ifu_req_addr = 32'h8000_0100;
        t_mem_req_ready = 1;
        t_accept(ok);
        n = 1;
        while (n < 30 && t_ifu_resp_valid !== 1'b1) begin tick(); n++; end
        checks++;
        if (n !== 6) begin failures++; $display("FAIL to_latency got %0d exp 6", n); end
        checks++;
        if ({t_ifu_resp_valid, t_ifu_resp_err, t_lsu_resp_valid} !== 3'b110 || t_ifu_resp_rdata !== 32'h0) begin
            failures++; $display("FAIL to_resp got v/err/lv=%b rd=%h exp 110 0",
                {t_ifu_resp_valid, t_ifu_resp_err, t_lsu_resp_valid}, t_ifu_resp_rdata);
        end
        t_ifu_resp_ready = 1; tick(); t_ifu_resp_ready = 0;
        checks++;
        if (t_mem_resp_ready !== 1'b1) begin
            failures++; $display("FAIL to_idle_ready got %b exp 1", t_mem_resp_ready);
        end
        use_fixed = 1; fixed_data = 32'hBAD0_BAD0;
        t_mem_resp_valid = 1; tick(); t_mem_resp_valid = 0; tick();
        checks++;
        if ({t_ifu_resp_valid, t_mem_req_valid, t_ifu_resp_err} !== 3'b000) begin
            failures++; $display("FAIL to_stray got %b exp 000", {t_ifu_resp_valid, t_mem_req_valid, t_ifu_resp_err});
        end
        fixed_data = 32'h1122_3344; t_mem_resp_valid = 1;
        t_accept(ok);
        n = 1;
        while (n < 30 && t_ifu_resp_valid !== 1'b1) begin tick(); n++; end
        checks++;
        if (n !== 3 || t_ifu_resp_rdata !== 32'h1122_3344 || t_ifu_resp_err !== 1'b0) begin
            failures++; $display("FAIL to_next got lat=%0d rd=%h err=%b exp 3 11223344 0",
                n, t_ifu_resp_rdata, t_ifu_resp_err);
        end
        t_ifu_resp_ready = 1; tick();
        idle_inputs(); tick();
    endtask

    task automatic test_reset_mid();
        logic ok;
        mreq_t ri, rl; resp_t orr, er;
        idle_inputs(); clear_queues(); use_fixed = 0;
        ri = '{32'h8000_0200, 1'b0, 32'h0, 4'h0, SZ_W};
        mem_req_ready = 1;
        issue(1'b0, ri, ok);
        tick();
        checks++;
        if ({mem_req_valid, mem_resp_ready} !== 2'b01) begin
            failures++; $display("FAIL mid_in_wait got %b exp 01", {mem_req_valid, mem_resp_ready});
        end
        reset = 1; tick(); reset = 0;
        checks++;
        if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_resp_ready} !== 4'b0001) begin
            failures++; $display("FAIL mid_reset_idle got %b exp 0001",
                {mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_resp_ready});
        end
        clear_queues();
        ri.addr = 32'h8000_0300;
        rl = '{32'h8000_4000, 1'b0, 32'h0, 4'h0, SZ_W};
        exp_resp.push_back('{1'b1, rl.addr ^ KEY, 1'b0});
        ifu_resp_ready = 1; lsu_resp_ready = 1; mem_req_ready = 1; mem_resp_valid = 1;
        ifu_req_valid = 1; ifu_req_addr = ri.addr;
        lsu_req_valid = 1; lsu_req_addr = rl.addr; lsu_req_wen = 0; lsu_req_wdata = 0;
        lsu_req_wmask = 0; lsu_req_size = SZ_W;
        for (int i = 0; i < 20 && obs_grant.size() < 1; i++) tick();
        ifu_req_valid = 0; lsu_req_valid = 0;
        wait_resps(1, ok);
        checks++;
        if (!ok || obs_grant.size() < 1) begin
            failures++; $display("FAIL mid_post_txn got grants=%0d resps=%0d exp 1", obs_grant.size(), obs_resp.size());
        end else begin
            checks++;
            if (obs_grant[0] !== 1'b1) begin
                failures++; $display("FAIL mid_first_grant got %b exp 1", obs_grant[0]);
            end
            orr = obs_resp.pop_front(); er = exp_resp.pop_front();
            checks++;
            if (orr !== er) begin failures++; $display("FAIL mid_resp got %h exp %h", orr, er); end
        end
        idle_inputs(); tick(); clear_queues();
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_tie();
        test_lsu_store();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
